// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffered transmit front-end for uart_tx.
// Bytes arrive on a valid/ready interface and are held in a circular FIFO.
// A small FSM pops one byte at a time, pulses tx_start_o for one cycle and
// paces on uart_tx's busy output, so reply bursts are not lost while a frame
// is in flight.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_data_i/valid_i byte to queue, qualified by valid
//   wr_ready_o        queue can accept (== !full_o)
//   tx_data_o         byte to uart_tx data_i, held from start pulse to next pop
//   tx_start_o        one-cycle start pulse to uart_tx start_i
//   tx_busy_i         uart_tx busy_o
//   count_o           entries stored, 0..DEPTH
//   full_o, empty_o   registered occupancy flags
//   overflow_o        sticky: write presented while full (byte dropped)
//   tx_err_o          sticky: busy never rose within BUSY_TIMEOUT cycles
//   err_clr_i         clears both sticky flags (a same-cycle set wins)
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             wr_data_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_busy_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  output logic                   tx_err_o,
  input  logic                   err_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wr_acc, pop, timeout;

  // Ready depends only on the pre-edge full flag, so a write while full is
  // refused even if a pop frees a slot on the same edge.
  assign wr_ready_o = !full_o;
  assign wr_acc     = wr_valid_i && !full_o;
  assign count_d    = count_o + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_o && !tx_busy_i) begin
          pop     = 1'b1;
          timer_d = '0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = WAIT_LO;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Give up on this byte: it counts as sent and is not retried.
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_o    <= '0;
      full_o     <= 1'b0;
      empty_o    <= 1'b1;
      tx_data_o  <= 8'h00;
      tx_start_o <= 1'b0;
      overflow_o <= 1'b0;
      tx_err_o   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_data_o <= mem[rd_ptr_q[AW-1:0]];
      end
      tx_start_o <= pop;
      count_o    <= count_d;
      full_o     <= (count_d == (AW+1)'(DEPTH));
      empty_o    <= (count_d == '0);
      overflow_o <= (wr_valid_i && full_o) || (overflow_o && !err_clr_i);
      tx_err_o   <= timeout || (tx_err_o && !err_clr_i);
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: accepted bytes are queued as expected
// transmissions; a monitor pops and compares on every start pulse, while the
// main process runs directed scenarios and checks status outputs.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int BT    = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy_hold = 1'b0;
  logic       busy_model = 1'b0;
  logic       bus_en = 1'b1;
  logic       tx_busy;
  int         frame_len = 100;

  logic       wr_ready, tx_start, full, empty, overflow, tx_err;
  logic [7:0] tx_data;
  logic [4:0] count;

  assign tx_busy = busy_hold | busy_model;

  uart_tx_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_busy_i(tx_busy),
    .count_o(count), .full_o(full), .empty_o(empty),
    .overflow_o(overflow), .tx_err_o(tx_err), .err_clr_i(err_clr)
  );

  always #10 clk = ~clk;

  int         n_chk = 0, n_pass = 0, n_start = 0;
  logic [7:0] exp_q[$];
  logic       prev_start = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every start pulse must be one cycle wide and carry the oldest
  // outstanding accepted byte.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_start) begin
      n_start++;
      chk("start_width", int'(prev_start), 0);
      if (exp_q.size() == 0) chk("unexpected_start", int'(tx_data), -1);
      else chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
    end
    prev_start = tx_start;
  end

  // uart_tx model: busy rises 2 cycles after a start, lasts frame_len cycles.
  initial forever begin
    @(negedge clk);
    if (tx_start && bus_en) begin
      @(negedge clk);
      @(negedge clk);
      busy_model = 1'b1;
      repeat (frame_len) @(negedge clk);
      busy_model = 1'b0;
    end
  end

  task automatic push(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    if (wr_ready) exp_q.push_back(b);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [7:0] b);
    int g = 0;
    while (!wr_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    push(b);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (frame_len + 6) @(negedge clk);
    chk("idle_empty", int'(empty), 1);
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ready", int'(wr_ready), 1);
    chk("rst_start", int'(tx_start), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_err", int'(tx_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single byte, start pulse one edge after the accept edge
    push(8'h41);
    chk("t1_count1", int'(count), 1);
    chk("t1_no_start_yet", int'(tx_start), 0);
    @(negedge clk);
    chk("t1_start", int'(tx_start), 1);
    @(negedge clk);
    chk("t1_start_low", int'(tx_start), 0);
    chk("t1_count0", int'(count), 0);
    wait_drain(300);
    chk("t1_starts", n_start, 1);

    // 2: burst to full, then in-order drain
    frame_len = 10;
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    chk("t2_full", int'(full), 1);
    chk("t2_count16", int'(count), 16);
    chk("t2_ready0", int'(wr_ready), 0);
    busy_hold = 1'b0;
    wait_drain(1000);
    chk("t2_ovf", int'(overflow), 0);
    chk("t2_starts", n_start, 17);

    // 3: overflow, clear, and set-beats-clear
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    chk("t3_ovf_pre", int'(overflow), 0);
    push(8'hEE);
    chk("t3_ovf_set", int'(overflow), 1);
    chk("t3_count", int'(count), 16);
    clr_pulse();
    chk("t3_ovf_clr", int'(overflow), 0);
    err_clr  = 1'b1;
    wr_data  = 8'hEE;
    wr_valid = 1'b1;
    @(negedge clk);
    err_clr  = 1'b0;
    wr_valid = 1'b0;
    chk("t3_set_wins", int'(overflow), 1);
    clr_pulse();
    chk("t3_ovf_clr2", int'(overflow), 0);
    busy_hold = 1'b0;
    wait_drain(1000);
    chk("t3_starts", n_start, 33);

    // 4: push and pop on the same edge, then 40 bytes through the wrap
    frame_len = 4;
    busy_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    chk("t4_count3", int'(count), 3);
    busy_hold = 1'b0;
    push(8'h63);
    chk("t4_pushpop_count", int'(count), 3);
    chk("t4_pushpop_start", int'(tx_start), 1);
    for (int i = 4; i < 40; i++) push_wait(8'h60 + 8'(i));
    wait_drain(2000);
    chk("t4_starts", n_start, 73);
    chk("t4_ovf", int'(overflow), 0);

    // 5: busy never rises -> timeout after BT cycles, next byte still sent
    bus_en = 1'b0;
    push(8'h55);
    push(8'h56);
    begin
      int k = 0;
      while (!tx_start && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t5_start_seen", int'(tx_start), 1);
    repeat (BT - 1) @(negedge clk);
    chk("t5_err_early", int'(tx_err), 0);
    @(negedge clk);
    chk("t5_err_set", int'(tx_err), 1);
    wait_drain(200);
    repeat (70) @(negedge clk);
    chk("t5_starts", n_start, 75);
    clr_pulse();
    chk("t5_err_clr", int'(tx_err), 0);
    bus_en = 1'b1;

    // 6: reset while a frame is in flight with bytes queued
    frame_len = 30;
    for (int i = 0; i < 6; i++) push(8'h80 + 8'(i));
    chk("t6_count5", int'(count), 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    chk("t6_count0", int'(count), 0);
    chk("t6_empty", int'(empty), 1);
    chk("t6_start", int'(tx_start), 0);
    chk("t6_ovf", int'(overflow), 0);
    chk("t6_err", int'(tx_err), 0);
    repeat (60) @(negedge clk);
    chk("t6_no_start", n_start, 76);
    push(8'h77);
    wait_drain(300);
    chk("t6_starts", n_start, 77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
